// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer (wr_pulse/wr_data in, rd_en/rd_data out, empty/full/almost_full/level/overrun status)
module uart_rx_fifo #(
  parameter int DBITS = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  wr_pulse,
  input  logic [DBITS-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  ovr_clr,
  output logic [DBITS-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overrun
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AF_LEVEL);
  logic [DBITS-1:0] mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic overrun_q, overrun_d, pop, push, drop;
  assign empty = level_q == '0;
  assign full = level_q == DEPTH_L;
  assign almost_full = level_q >= AF_L;
  assign level = level_q;
  assign overrun = overrun_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign pop = rd_en & ~empty;
  assign push = wr_pulse & (~full | pop);
  assign drop = wr_pulse & full & ~pop;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    level_d = (push & ~pop) ? level_q + (ADDR_WIDTH+1)'(1) :
              (pop & ~push) ? level_q - (ADDR_WIDTH+1)'(1) : level_q;
    overrun_d = drop | (overrun_q & ~ovr_clr);
  end
  always_ff @(posedge clk_100MHz) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 1'b0, reset_n = 1'b0, wr_pulse = 1'b0, rd_en = 1'b0, ovr_clr = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic empty, full, almost_full, overrun;
  logic [4:0] level;
  int checks = 0, errors = 0;
  uart_rx_fifo dut (
    .clk_100MHz(clk), .reset_n(reset_n), .wr_pulse(wr_pulse), .wr_data(wr_data),
    .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data), .empty(empty), .full(full),
    .almost_full(almost_full), .level(level), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    wr_pulse = 1'b0;
    rd_en = 1'b0;
    ovr_clr = 1'b0;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_pulse = 1'b1;
    wr_data = d;
    step();
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1'b1;
    step();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovr", overrun, 0);
    wr(8'hA5);
    chk("t1_empty", empty, 0);
    chk("t1_level", level, 1);
    chk("t1_data", rd_data, 8'hA5);
    rd_en = 1'b1;
    step();
    chk("t1_pop_empty", empty, 1);
    chk("t1_pop_level", level, 0);
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      chk("t2_af", almost_full, (i + 1) >= 12);
      chk("t2_level", level, i + 1);
    end
    chk("t2_full", full, 1);
    for (int i = 0; i < 16; i++) pop_chk("t2_data", 8'(i));
    chk("t2_empty", empty, 1);
    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'h55);
    chk("t3_ovr", overrun, 1);
    chk("t3_level", level, 16);
    for (int i = 0; i < 16; i++) pop_chk("t3_data", 8'(i));
    chk("t3_empty", empty, 1);
    chk("t3_ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    step();
    chk("t3_clr", overrun, 0);
    for (int i = 0; i < 16; i++) wr(8'(i));
    rd_en = 1'b1;
    wr(8'h77);
    chk("t4_level", level, 16);
    chk("t4_ovr", overrun, 0);
    chk("t4_head", rd_data, 8'h01);
    ovr_clr = 1'b1;
    wr(8'h99);
    chk("t4_set_wins", overrun, 1);
    for (int i = 1; i < 16; i++) pop_chk("t4_data", 8'(i));
    pop_chk("t4_last", 8'h77);
    chk("t4_empty", empty, 1);
    ovr_clr = 1'b1;
    step();
    rd_en = 1'b1;
    wr(8'h3C);
    chk("t5_level", level, 1);
    chk("t5_data", rd_data, 8'h3C);
    pop_chk("t5_pop", 8'h3C);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step();
      chk("t5_idle_level", level, 0);
      chk("t5_idle_empty", empty, 1);
    end
    wr(8'hC3);
    chk("t5_ptr_hold", rd_data, 8'hC3);
    pop_chk("t5_ptr_pop", 8'hC3);
    for (int k = 0; k < 40; k++) begin
      wr(8'(k * 7 + 3));
      pop_chk("t5_wrap", 8'(k * 7 + 3));
    end
    chk("t5_wrap_level", level, 0);
    for (int i = 0; i < 16; i++) wr(8'(i + 8'h40));
    wr(8'hEE);
    for (int i = 0; i < 9; i++) pop_chk("t6_pre", 8'(i + 8'h40));
    chk("t6_level7", level, 7);
    chk("t6_ovr_pre", overrun, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_empty", empty, 1);
    chk("t6_async_level", level, 0);
    chk("t6_async_ovr", overrun, 0);
    reset_n = 1'b1;
    wr(8'h81);
    chk("t6_level", level, 1);
    chk("t6_data", rd_data, 8'h81);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
